// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine.
// One output byte is produced per cycle over 16 CALC cycles; the full result
// is published on o_data in a single update at DONE entry, so o_data always
// holds a complete, consistent state.
module mix_columns_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_inverse,
    input  logic [127:0] i_data,
    output logic         o_busy,
    output logic         o_done,
    output logic [127:0] o_data
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    // Byte arrays indexed [~column][~row] so that column 0 / row 0 sit in the
    // most significant byte, matching the column-major i_data layout.
    logic [3:0][3:0][7:0] din;
    logic [3:0][3:0][7:0] acc;
    logic                 inv;
    logic [3:0]           cnt;
    logic [1:0]           col, row, kk;
    logic [7:0]           byte_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant: sum of b, 2b, 4b, 8b selected by
    // the coefficient bits, built from three chained xtime steps.
    function automatic logic [7:0] gmul(input logic [3:0] k, input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
    endfunction

    // Coefficient rows are rotations of a base row; idx = (k - r) mod 4.
    function automatic logic [3:0] coeff(input logic inverse, input logic [1:0] idx);
        logic [3:0] c;
        case (idx)
            2'd0:    c = inverse ? 4'hE : 4'h2;
            2'd1:    c = inverse ? 4'hB : 4'h3;
            2'd2:    c = inverse ? 4'hD : 4'h1;
            default: c = inverse ? 4'h9 : 4'h1;
        endcase
        return c;
    endfunction

    assign col    = cnt[3:2];
    assign row    = cnt[1:0];
    assign o_busy = (state == CALC);
    assign o_done = (state == DONE);

    // Dot product of one coefficient row with the selected input column.
    always_comb begin
        byte_out = '0;
        kk       = '0;
        for (int k = 0; k < 4; k++) begin
            kk       = 2'(k);
            byte_out = byte_out ^ gmul(coeff(inv, kk - row), din[~col][~kk]);
        end
    end

    // Next-state logic: start accepted only outside CALC; CALC ends after byte 15.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = i_start ? CALC : IDLE;
            CALC:    state_nxt = (cnt == 4'd15) ? DONE : CALC;
            DONE:    state_nxt = i_start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand latch, byte counter, working result and published output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din    <= '0;
            inv    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            o_data <= '0;
        end else begin
            case (state)
                CALC: begin
                    acc[~col][~row] <= byte_out;
                    cnt             <= cnt + 4'd1;
                    // Last byte goes straight into the published result.
                    if (cnt == 4'd15)
                        o_data <= {acc[3], acc[2], acc[1], acc[0][3], acc[0][2], acc[0][1], byte_out};
                end
                default: begin
                    if (i_start) begin
                        din <= i_data;
                        inv <= i_inverse;
                        cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule
